// File: rtl/rr_sel_pkg.sv
// rr_sel_pkg -- shared types and constants for the round-robin select arbiter.
//   state_t       : arbiter FSM states (IDLE, BUSY)
//   SEL_W         : width of the mux select index
//   NUM_CH        : number of requesting channels
//   BURST_LEN_DEF : default beats per grant
//   idx_to_onehot : converts a channel index to a one-hot grant vector
package rr_sel_pkg;

  localparam int SEL_W         = 2;
  localparam int NUM_CH        = 4;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_sel_pick.sv
// rr_sel_pick -- combinational next-channel finder.
//   req   [3:0] : per-channel requests
//   ptr   [1:0] : last granted index; the search starts at ptr+1 and ptr itself is tried last
//   prio0       : when set, channel 0 wins whenever it requests
//   idx   [1:0] : chosen channel index (ptr when nothing is found)
//   found       : at least one request was present
module rr_sel_pick
  import rr_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              prio0,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1),
    // so the nearest requesting channel is the one left standing.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    if (prio0 && req[0]) begin
      idx   = '0;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter -- round-robin burst arbiter driving the select lines of a 4:1 mux.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   req  [3:0] : per-channel request
//   ready      : downstream accepts the current beat
//   s0, s1     : registered mux select (LSB, MSB)
//   grant[3:0] : registered one-hot grant, zero when idle
//   valid      : registered, selected mux output carries a live beat
// Parameter BURST_LEN (1..16) sets the beats per grant.
// Build option: define RR_SEL_PRIO0_EN to give channel 0 absolute priority at
// every arbitration decision (running bursts are never preempted); otherwise
// arbitration is pure round-robin.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              ready,
  output logic              s0,
  output logic              s1,
  output logic [NUM_CH-1:0] grant,
  output logic              valid
);

`ifdef RR_SEL_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t            state, state_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [3:0]        cnt, cnt_n;
  logic [NUM_CH-1:0] grant_r, grant_n;
  logic [SEL_W-1:0]  sel_r, sel_n;
  logic              valid_r, valid_n;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              accept;
  logic              last_accept;
  logic              owner_live;

  rr_sel_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .prio0 (PRIO0),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign accept      = valid_r & ready;
  assign last_accept = accept && (cnt == LAST_BEAT);
  assign owner_live  = |(req & grant_r);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant_r;
    sel_n   = sel_r;
    valid_n = valid_r;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        grant_n = '0;
        if (pick_found) begin
          state_n = BUSY;
          grant_n = idx_to_onehot(pick_idx);
          sel_n   = pick_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
          ptr_n   = pick_idx;
        end
      end
      BUSY: begin
        if (last_accept) begin
          // Burst complete: hand over back-to-back; ptr already holds the
          // current owner, so it is considered last.
          if (pick_found) begin
            grant_n = idx_to_onehot(pick_idx);
            sel_n   = pick_idx;
            valid_n = 1'b1;
            cnt_n   = '0;
            ptr_n   = pick_idx;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            valid_n = 1'b0;
            cnt_n   = '0;
          end
        end else if (!owner_live) begin
          // Owner withdrew: abandon the burst, keep ptr, still count a beat
          // taken on this edge.
          state_n = IDLE;
          grant_n = '0;
          valid_n = 1'b0;
          if (accept) cnt_n = cnt + 4'd1;
        end else if (accept) begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= SEL_W'(NUM_CH - 1);
      cnt     <= '0;
      grant_r <= '0;
      sel_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      grant_r <= grant_n;
      sel_r   <= sel_n;
      valid_r <= valid_n;
    end
  end

  assign s0    = sel_r[0];
  assign s1    = sel_r[1];
  assign grant = grant_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter -- directed bench for rr_sel_arbiter (BURST_LEN = 4) with a
// second instance at BURST_LEN = 1 sharing the same stimulus.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;
  logic       s0, s1, valid;
  logic [3:0] grant;
  logic       u1_s0, u1_s1, u1_valid;
  logic [3:0] u1_grant;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .s0(s0), .s1(s1), .grant(grant), .valid(valid)
  );

  rr_sel_arbiter #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .s0(u1_s0), .s1(u1_s1), .grant(u1_grant), .valid(u1_valid)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] sel, input logic v);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".sel"}, {2'b00, s1, s0}, {2'b00, sel});
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_out("rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b1;
    do_reset();
    chk("rst.u1_grant", u1_grant, 4'b0000);

    // Single requester on channel 2
    req = 4'b0100;
    tick();
    chk_out("single.b0", 4'b0100, 2'd2, 1'b1);
    tick(); chk_out("single.b1", 4'b0100, 2'd2, 1'b1);
    tick(); chk_out("single.b2", 4'b0100, 2'd2, 1'b1);
    tick(); chk_out("single.b3", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("single.idle", 4'b0000, 2'd2, 1'b0);

    // Fairness with all channels requesting; BURST_LEN=1 rotates every cycle
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        chk_out($sformatf("fair.b%0d.k%0d", b, k), 4'b0001 << (b % 4), 2'(b % 4), 1'b1);
        chk($sformatf("fair1.t%0d", b * 4 + k), u1_grant, 4'b0001 << ((b * 4 + k) % 4));
      end
    end
    req = 4'b0000;
    tick();
    chk_out("fair.idle", 4'b0000, 2'd0, 1'b0);

    // Backpressure on channel 1; channel 0 joins and takes over exactly after beat 3
    do_reset();
    req = 4'b0010;
    tick();
    chk_out("bp.grant", 4'b0010, 2'd1, 1'b1);
    req = 4'b0011;
    tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("bp.frz%0d", k), 4'b0010, 2'd1, 1'b1);
    end
    ready = 1'b1;
    tick(); chk_out("bp.b2", 4'b0010, 2'd1, 1'b1);
    tick(); chk_out("bp.b3", 4'b0010, 2'd1, 1'b1);
    tick(); chk_out("bp.next", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk_out("bp.idle", 4'b0000, 2'd0, 1'b0);

    // Abort: channel 2 drops after two beats, ptr stays at 2
    do_reset();
    req = 4'b0100;
    tick();
    chk_out("abort.grant", 4'b0100, 2'd2, 1'b1);
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk_out("abort.idle", 4'b0000, 2'd2, 1'b0);
    req = 4'b0110;
    tick();
    chk_out("abort.regrant", 4'b0010, 2'd1, 1'b1);

    // Asynchronous reset mid-burst on channel 1
    tick();
    tick();
    chk_out("arst.pre", 4'b0010, 2'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst.now", 4'b0000, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    chk_out("arst.ch3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    tick();

    // Arbitration policy with channels 0 and 1 both requesting
    do_reset();
    req = 4'b0011;
    tick();
    chk("prio.burst0", grant, 4'b0001);
    for (int k = 0; k < 4; k++) tick();
`ifdef RR_SEL_PRIO0_EN
    chk("prio.burst1", grant, 4'b0001);
`else
    chk("prio.burst1", grant, 4'b0010);
`endif
    for (int k = 0; k < 4; k++) tick();
    chk("prio.burst2", grant, 4'b0001);
    req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
